// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter generator for the single-cycle CPU.
// Produces the sequential fetch address itself and arbitrates trap, return,
// jump/call and branch redirects. A small circular return-address stack
// holds call return addresses. The whole block freezes while instruction
// memory reports busywait.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b1}} - {{(WIDTH-2){1'b0}}, 2'b11},
  parameter int               INC       = 4,
  parameter logic [31:0]      TRAP_VEC  = 32'h0000_0100,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             busywait,
  input  logic             trap,
  input  logic             ret,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] INC_V    = WIDTH'(INC);
  localparam logic [WIDTH-1:0] TRAP_V   = WIDTH'(TRAP_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  // Registered state
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             unf_r;

  // Next-state terms
  logic [WIDTH-1:0] pc_plus_s;
  logic [WIDTH-1:0] pc_next_s;
  logic [PTR_W-1:0] top_inc_s;
  logic [PTR_W-1:0] top_dec_s;
  logic [PTR_W-1:0] top_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             push_s;
  logic             pop_s;
  logic             ovf_s;
  logic             unf_s;

  // Sequential address and circular pointer neighbours (wrap also covers
  // stack depths that are not a power of two).
  always_comb begin
    pc_plus_s = pc_r + INC_V;
    if (top_r == PTR_LAST) begin
      top_inc_s = PTR_ZERO;
    end else begin
      top_inc_s = top_r + PTR_ONE;
    end
    if (top_r == PTR_ZERO) begin
      top_dec_s = PTR_LAST;
    end else begin
      top_dec_s = top_r - PTR_ONE;
    end
  end

  // Redirect arbitration: trap > ret > jump/call > branch > sequential.
  // Losing requests have no side effects, so a call beaten by trap/ret never pushes.
  always_comb begin
    pc_next_s = pc_plus_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_s     = 1'b0;
    unf_s     = 1'b0;
    if (trap) begin
      pc_next_s = TRAP_V;
    end else if (ret) begin
      if (cnt_r != CNT_ZERO) begin
        pc_next_s = ras_r[top_r];
        pop_s     = 1'b1;
      end else begin
        pc_next_s = pc_plus_s;
        unf_s     = 1'b1;
      end
    end else if (jump) begin
      pc_next_s = jump_target;
      push_s    = call;
      ovf_s     = call && (cnt_r == CNT_MAX);
    end else if (branch_taken) begin
      pc_next_s = branch_target;
    end else begin
      pc_next_s = pc_plus_s;
    end
  end

  // Stack pointer and occupancy update; a push onto a full stack keeps the
  // count saturated and silently overwrites the oldest entry.
  always_comb begin
    top_next_s = top_r;
    cnt_next_s = cnt_r;
    if (push_s) begin
      top_next_s = top_inc_s;
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = CNT_MAX;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else if (pop_s) begin
      top_next_s = top_dec_s;
      cnt_next_s = cnt_r - CNT_ONE;
    end else begin
      top_next_s = top_r;
      cnt_next_s = cnt_r;
    end
  end

  // State register: async reset, full freeze on busywait (pulses drop to 0).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_r  <= RESET_VEC;
      top_r <= PTR_ZERO;
      cnt_r <= CNT_ZERO;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= {WIDTH{1'b0}};
      end
    end else if (busywait) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_next_s;
      top_r <= top_next_s;
      cnt_r <= cnt_next_s;
      ovf_r <= ovf_s;
      unf_r <= unf_s;
      if (push_s) begin
        ras_r[top_inc_s] <= pc_plus_s;
      end
    end
  end

  assign PC            = pc_r;
  assign PC_plus       = pc_plus_s;
  assign ras_empty     = (cnt_r == CNT_ZERO);
  assign ras_full      = (cnt_r == CNT_MAX);
  assign ras_overflow  = ovf_r;
  assign ras_underflow = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (default parameters).
// Stimulus runs on the falling edge, advances a queue-based reference model
// and pushes the expected post-edge state; a monitor pops and compares after
// each rising edge.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC = 32'hFFFF_FFFC;
  localparam logic [31:0] TRAPV   = 32'h0000_0100;
  localparam int          DEPTH   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        busywait, trap, ret, jump, call, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic [31:0] PC, PC_plus;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic        ovf;
    logic        unf;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_sequencer dut (
    .CLK(CLK), .RESET(RESET), .busywait(busywait), .trap(trap), .ret(ret),
    .jump(jump), .call(call), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .PC(PC), .PC_plus(PC_plus), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_pc = RST_VEC;
    m_ras.delete();
  endtask

  // Drive one cycle of requests, advance the model, queue the expectation.
  task automatic issue(input logic b, input logic t, input logic r, input logic j,
                       input logic c, input logic [31:0] jt, input logic br,
                       input logic [31:0] bt);
    exp_t e;
    busywait = b; trap = t; ret = r; jump = j; call = c;
    jump_target = jt; branch_taken = br; branch_target = bt;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (!b) begin
      if (t) begin
        m_pc = TRAPV;
      end else if (r) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc  = m_pc + 32'd4;
          e.unf = 1'b1;
        end
      end else if (j) begin
        if (c) begin
          if (m_ras.size() == DEPTH) begin
            m_ras.delete(0);
            e.ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd4);
        end
        m_pc = jt;
      end else if (br) begin
        m_pc = bt;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc    = m_pc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic b, input logic t, input logic r, input logic j,
                     input logic c, input logic [31:0] jt, input logic br,
                     input logic [31:0] bt);
    @(negedge CLK);
    issue(b, t, r, j, c, jt, br, bt);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic jmp(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, 1'b0, 32'h0);
  endtask

  task automatic async_reset_check();
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_rst_pc", PC, RST_VEC);
    chk("async_rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("async_rst_ovf", {31'd0, ras_overflow}, 32'd0);
    chk("async_rst_unf", {31'd0, ras_underflow}, 32'd0);
    mreset();
    @(negedge CLK);
    RESET = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compare DUT state shortly after every rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", PC, e.pc);
      chk("pc_plus", PC_plus, e.pc + 32'd4);
      chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
      chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.empty});
      chk("ras_full", {31'd0, ras_full}, {31'd0, e.full});
    end
  end

  initial begin
    RESET = 1'b1;
    busywait = 1'b0; trap = 1'b0; ret = 1'b0; jump = 1'b0; call = 1'b0;
    branch_taken = 1'b0; jump_target = 32'h0; branch_target = 32'h0;
    mreset();
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_pc", PC, RST_VEC);
    chk("reset_pc_plus", PC_plus, 32'h0);
    chk("reset_empty", {31'd0, ras_empty}, 32'd1);
    chk("reset_full", {31'd0, ras_full}, 32'd0);
    RESET = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    idle();

    // Stall with a held jump, then release
    jmp(32'h10);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);

    // Every request at once: trap wins, no push
    jmp(32'h20);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400);

    // Five calls overflow a 4-deep stack, then four returns
    jmp(32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'(k) << 8, 1'b0, 32'h0);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Return with an empty stack falls through
    jmp(32'h40);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();

    // Wrap from the top of the address space
    jmp(32'hFFFF_FFFC);
    idle();

    // Branch, call without jump
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h600);
    idle();

    async_reset_check();

    for (int i = 0; i < 600; i++) begin
      logic [31:0] jt, bt;
      jt = $urandom();
      bt = $urandom();
      if (i == 300) begin
        async_reset_check();
      end
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 1) == 0), jt, ($urandom_range(0, 3) == 0), bt);
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge CLK);
    end
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
